// File: rtl/uart_tx.sv
// UART transmitter: start bit, BIT data bits LSB first, optional even parity, one stop bit.
// Define UART_TX_PARITY_EN to insert the even-parity bit between the data bits and the stop bit.
module uart_tx #(
  parameter int unsigned CLK_FREQ  = 20000000,
  parameter int unsigned BAUD_RATE = 57600,
  parameter int unsigned BIT       = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [BIT-1:0] tx_data,
  input  logic           tx_data_start,
  output logic           tx_ready,
  output logic           tx_busy,
  output logic           tx_done,
  output logic           tx_pin
);

  localparam int unsigned CYCLE = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CNT_W = (CYCLE > 1) ? $clog2(CYCLE) : 1;
  localparam int unsigned BIT_W = (BIT > 1) ? $clog2(BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [BIT_W-1:0] bit_cnt, bit_d;
  logic [BIT-1:0]   shreg, shreg_d;
  logic [BIT-1:0]   hold, hold_d;
  logic             hold_full_d;
  logic             stop_end, stop_end_c;
  logic             line_c;
  logic             accept_c;
  logic             last_c;
`ifdef UART_TX_PARITY_EN
  logic             par, par_d;
`endif

  assign accept_c = tx_data_start & tx_ready;
  assign last_c   = (cnt == CNT_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next state, datapath next values and line level
  always_comb begin
    state_d     = state;
    cnt_d       = last_c ? '0 : cnt + CNT_W'(1);
    bit_d       = bit_cnt;
    shreg_d     = shreg;
    hold_d      = hold;
    hold_full_d = ~tx_ready;
`ifdef UART_TX_PARITY_EN
    par_d       = par;
`endif
    line_c      = 1'b1;
    stop_end_c  = 1'b0;

    // A request outside IDLE parks the word; STOP's last clock may pull it straight through
    if (accept_c && (state != IDLE)) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end

    case (state)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (accept_c) begin
          shreg_d = tx_data;
`ifdef UART_TX_PARITY_EN
          par_d   = ^tx_data;
`endif
          state_d = START;
        end
      end
      START: begin
        line_c = 1'b0;
        if (last_c) state_d = DATA;
      end
      DATA: begin
        line_c = shreg[0];
        if (last_c) begin
          shreg_d = shreg >> 1;
          if (bit_cnt == BIT_LAST) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_cnt + BIT_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        line_c = par;
        if (last_c) state_d = STOP;
      end
`endif
      STOP: begin
        line_c = 1'b1;
        if (last_c) begin
          stop_end_c = 1'b1;
          if (!tx_ready) begin
            shreg_d     = hold;
`ifdef UART_TX_PARITY_EN
            par_d       = ^hold;
`endif
            hold_full_d = 1'b0;
            state_d     = START;
          end else if (accept_c) begin
            shreg_d     = tx_data;
`ifdef UART_TX_PARITY_EN
            par_d       = ^tx_data;
`endif
            hold_full_d = 1'b0;
            state_d     = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs; outputs trail the state by one clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      hold     <= '0;
`ifdef UART_TX_PARITY_EN
      par      <= 1'b0;
`endif
      stop_end <= 1'b0;
      tx_ready <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
      tx_pin   <= 1'b1;
    end else begin
      cnt      <= cnt_d;
      bit_cnt  <= bit_d;
      shreg    <= shreg_d;
      hold     <= hold_d;
`ifdef UART_TX_PARITY_EN
      par      <= par_d;
`endif
      stop_end <= stop_end_c;
      tx_ready <= ~hold_full_d;
      tx_busy  <= (state != IDLE);
      tx_done  <= stop_end;
      tx_pin   <= line_c;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: scoreboard of expected words checked by a line monitor, plus timing checks.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int CYCLE = 347;
`ifdef UART_TX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  localparam int FRAME  = (8 + 2 + PBITS) * CYCLE;
  localparam int FRAME7 = (7 + 2 + PBITS) * CYCLE;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_data_start = 1'b0;
  logic       tx_ready, tx_busy, tx_done, tx_pin;
  logic [6:0] d7_data = '0;
  logic       d7_start = 1'b0;
  logic       d7_ready, d7_busy, d7_done, d7_pin;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic aborted = 1'b0;
  logic [7:0] exp_q[$];
  int fall_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge rst_n) aborted = 1'b1;

  uart_tx #(.CLK_FREQ(20000000), .BAUD_RATE(57600), .BIT(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_data_start(tx_data_start),
    .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_done(tx_done), .tx_pin(tx_pin)
  );

  uart_tx #(.CLK_FREQ(20000000), .BAUD_RATE(57600), .BIT(7)) u_dut7 (
    .clk(clk), .rst_n(rst_n), .tx_data(d7_data), .tx_data_start(d7_start),
    .tx_ready(d7_ready), .tx_busy(d7_busy), .tx_done(d7_done), .tx_pin(d7_pin)
  );

  // Line monitor: decode frames at bit centres and check them against the scoreboard
  logic [7:0] m_word, m_exp;
  logic       m_start, m_par, m_stop;
  int         m_fall;
  always begin
    @(posedge clk); #1;
    if (rst_n === 1'b1 && tx_pin === 1'b0) begin
      m_fall  = cyc;
      aborted = 1'b0;
      repeat (CYCLE / 2) @(posedge clk);
      #1 m_start = tx_pin;
      for (int i = 0; i < 8; i++) begin
        repeat (CYCLE) @(posedge clk);
        #1 m_word[i] = tx_pin;
      end
      m_par = 1'b0;
`ifdef UART_TX_PARITY_EN
      repeat (CYCLE) @(posedge clk);
      #1 m_par = tx_pin;
`endif
      repeat (CYCLE) @(posedge clk);
      #1 m_stop = tx_pin;
      if (!aborted) begin
        fall_q.push_back(m_fall);
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL frame_unexpected: got word %h, none expected", m_word);
        end else begin
          m_exp = exp_q.pop_front();
          if ({m_start, m_word, m_stop} !== {1'b0, m_exp, 1'b1}) begin
            miscompares++;
            $display("FAIL frame_bits: got start %b word %h stop %b, want 0 %h 1",
                     m_start, m_word, m_stop, m_exp);
          end
`ifdef UART_TX_PARITY_EN
          vectors++;
          if (m_par !== ^m_exp) begin
            miscompares++;
            $display("FAIL frame_parity: word %h got %b want %b", m_exp, m_par, ^m_exp);
          end
`endif
        end
      end
    end
  end

  task automatic drive_start(input logic [7:0] d);
    @(negedge clk);
    tx_data = d;
    tx_data_start = 1'b1;
    @(posedge clk); #1;
    tx_data_start = 1'b0;
  endtask

  task automatic wait_done(input int n, input int limit, output int seen);
    seen = 0;
    for (int k = 0; k < limit && seen < n; k++) begin
      @(posedge clk); #1;
      if (tx_done === 1'b1) seen++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({tx_pin, tx_busy, tx_done, tx_ready} !== 4'b1001) begin
      miscompares++;
      $display("FAIL reset_outputs: got pin/busy/done/ready %b, want 1001",
               {tx_pin, tx_busy, tx_done, tx_ready});
    end
    vectors++;
    if ({d7_pin, d7_busy, d7_done, d7_ready} !== 4'b1001) begin
      miscompares++;
      $display("FAIL reset_outputs7: got %b want 1001", {d7_pin, d7_busy, d7_done, d7_ready});
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_single();
    int fall_at = -1, done_at = -1, dones = 0, busy = 0;
    exp_q.push_back(8'hA5);
    drive_start(8'hA5);
    for (int k = 1; k <= FRAME + 20; k++) begin
      @(posedge clk); #1;
      if (fall_at < 0 && tx_pin === 1'b0) fall_at = k;
      if (tx_busy === 1'b1) busy++;
      if (tx_done === 1'b1) begin dones++; done_at = k; end
    end
    vectors++;
    if (fall_at != 1) begin miscompares++; $display("FAIL single_fall: got %0d want 1", fall_at); end
    vectors++;
    if (busy != FRAME) begin miscompares++; $display("FAIL single_busy: got %0d want %0d", busy, FRAME); end
    vectors++;
    if (dones != 1) begin miscompares++; $display("FAIL single_done_count: got %0d want 1", dones); end
    vectors++;
    if (done_at - fall_at != FRAME) begin
      miscompares++;
      $display("FAIL single_done_time: got %0d want %0d", done_at - fall_at, FRAME);
    end
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL single_sb: %0d left, want 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    int seen;
    fall_q.delete();
    exp_q.push_back(8'h55);
    drive_start(8'h55);
    repeat (100) @(posedge clk);
    exp_q.push_back(8'h0F);
    drive_start(8'h0F);
    vectors++;
    if (tx_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_ready_held: got %b want 0", tx_ready); end
    drive_start(8'h99);
    vectors++;
    if (tx_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_ready_ignore: got %b want 0", tx_ready); end
    wait_done(2, 3 * FRAME, seen);
    vectors++;
    if (seen != 2) begin miscompares++; $display("FAIL b2b_done_count: got %0d want 2", seen); end
    repeat (FRAME) @(posedge clk);
    #1;
    vectors++;
    if (fall_q.size() != 2) begin
      miscompares++;
      $display("FAIL b2b_frames: got %0d frames want 2", fall_q.size());
    end else begin
      vectors++;
      if (fall_q[1] - fall_q[0] != FRAME) begin
        miscompares++;
        $display("FAIL b2b_gap: got spacing %0d want %0d", fall_q[1] - fall_q[0], FRAME);
      end
    end
    vectors++;
    if (exp_q.size() != 0 || tx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_end: got %0d left ready %b, want 0 left ready 1", exp_q.size(), tx_ready);
    end
  endtask

  task automatic test_last_stop();
    int seen;
    fall_q.delete();
    exp_q.push_back(8'hFF);
    drive_start(8'hFF);
    repeat (FRAME - 1) @(posedge clk);
    @(negedge clk);
    tx_data = 8'h81;
    tx_data_start = 1'b1;
    exp_q.push_back(8'h81);
    @(posedge clk); #1;
    tx_data_start = 1'b0;
    wait_done(2, 3 * FRAME, seen);
    vectors++;
    if (seen != 2) begin miscompares++; $display("FAIL last_stop_done: got %0d want 2", seen); end
    vectors++;
    if (fall_q.size() != 2 || fall_q[1] - fall_q[0] != FRAME) begin
      miscompares++;
      $display("FAIL last_stop_gap: got %0d frames, want 2 spaced %0d", fall_q.size(), FRAME);
    end
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL last_stop_sb: %0d left, want 0", exp_q.size()); end
  endtask

  task automatic test_parity_words();
    int seen;
    exp_q.push_back(8'h07);
    drive_start(8'h07);
    wait_done(1, FRAME + 50, seen);
    vectors++;
    if (seen != 1) begin miscompares++; $display("FAIL word07_done: got %0d want 1", seen); end
    exp_q.push_back(8'h03);
    drive_start(8'h03);
    wait_done(1, FRAME + 50, seen);
    vectors++;
    if (seen != 1) begin miscompares++; $display("FAIL word03_done: got %0d want 1", seen); end
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL parity_sb: %0d left, want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int seen;
    fall_q.delete();
    drive_start(8'h00);
    repeat (999) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    vectors++;
    if ({tx_pin, tx_busy, tx_done, tx_ready} !== 4'b1001) begin
      miscompares++;
      $display("FAIL abort_outputs: got pin/busy/done/ready %b want 1001",
               {tx_pin, tx_busy, tx_done, tx_ready});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_done(1, 4000, seen);
    vectors++;
    if (seen != 0 || fall_q.size() != 0) begin
      miscompares++;
      $display("FAIL abort_no_done: got %0d dones %0d frames, want 0 0", seen, fall_q.size());
    end
    exp_q.push_back(8'h3C);
    drive_start(8'h3C);
    wait_done(1, FRAME + 50, seen);
    vectors++;
    if (seen != 1 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL after_reset: got %0d dones %0d left, want 1 0", seen, exp_q.size());
    end
  endtask

  task automatic test_bit7(input logic [6:0] v);
    logic bits[11];
    int nb, idx = 0, busy = 0, dones = 0;
    bits[0] = 1'b0;
    for (int i = 0; i < 7; i++) bits[i + 1] = v[i];
    nb = 8;
`ifdef UART_TX_PARITY_EN
    bits[nb] = ^v;
    nb++;
`endif
    bits[nb] = 1'b1;
    nb++;
    @(negedge clk);
    d7_data = v;
    d7_start = 1'b1;
    @(posedge clk); #1;
    d7_start = 1'b0;
    for (int k = 1; k <= FRAME7 + 20; k++) begin
      @(posedge clk); #1;
      if (d7_busy === 1'b1) busy++;
      if (d7_done === 1'b1) dones++;
      if ((k - 1) % CYCLE == CYCLE / 2 && idx < nb) begin
        vectors++;
        if (d7_pin !== bits[idx]) begin
          miscompares++;
          $display("FAIL bit7_line: word %h bit %0d got %b want %b", v, idx, d7_pin, bits[idx]);
        end
        idx++;
      end
    end
    vectors++;
    if (busy != FRAME7 || dones != 1) begin
      miscompares++;
      $display("FAIL bit7_frame: word %h got busy %0d dones %0d want %0d 1", v, busy, dones, FRAME7);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_last_stop();
    test_parity_words();
    test_reset_mid();
    test_bit7(7'h7F);
    test_bit7(7'h15);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
